// File: rtl/dadda_cpa_pipe_pkg.sv
// Shared constants and types for the 8x8 Dadda multiplier datapath.
package dadda_cpa_pipe_pkg;
  localparam int W    = 16;
  localparam int HALF = W / 2;

  typedef logic [W-1:0] row_t;
endpackage

// File: rtl/dadda_cpa_pipe_rca_slice.sv
// Ripple-carry slice of one-bit full-adder cells, used once per pipeline stage.
import dadda_cpa_pipe_pkg::*;

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice #(
  parameter int HALF = 8
) (
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            cin,
  output logic [HALF-1:0] sum,
  output logic            cout
);
  logic [HALF:0] c;

  assign c[0] = cin;
  assign cout = c[HALF];

  // Bit i consumes c[i] and produces c[i+1]; the chain is the critical path.
  fa_cell u_fa [HALF-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[HALF-1:0]),
    .s  (sum),
    .co (c[HALF:1])
  );
endmodule

// File: rtl/dadda_cpa_pipe.sv
// Two-stage pipelined carry-propagate adder closing the Dadda tree, with
// valid/ready on both sides.
import dadda_cpa_pipe_pkg::*;

module dadda_cpa_pipe #(
  parameter int W = dadda_cpa_pipe_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] row_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] prod,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int HALF   = W / 2;
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [HALF-1:0] lo_sum, a_hi, b_hi;
  logic            c_mid;
  logic [HALF-1:0] lo_nxt, hi_sum;
  logic            c_nxt, hi_cout;
  logic            s1_ready, s2_ready;

  assign s2_ready  = !vld_pipe[2] | out_ready;
  assign s1_ready  = !vld_pipe[1] | s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = vld_pipe[2];

  rca_slice #(.HALF(HALF)) u_lo (
    .a    (row_a[HALF-1:0]),
    .b    (row_b[HALF-1:0]),
    .cin  (1'b0),
    .sum  (lo_nxt),
    .cout (c_nxt)
  );

  rca_slice #(.HALF(HALF)) u_hi (
    .a    (a_hi),
    .b    (b_hi),
    .cin  (c_mid),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      lo_sum   <= '0;
      c_mid    <= 1'b0;
      a_hi     <= '0;
      b_hi     <= '0;
      prod     <= '0;
      ovf      <= 1'b0;
    end else begin
      // Data registers only load on a real transfer so a stalled stage holds.
      if (s1_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          lo_sum <= lo_nxt;
          c_mid  <= c_nxt;
          a_hi   <= row_a[W-1:HALF];
          b_hi   <= row_b[W-1:HALF];
        end
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          prod <= {hi_sum, lo_sum};
          ovf  <= hi_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_dadda_cpa_pipe.sv
// Self-checking bench: directed vector table, backpressure/reset sequences,
// and random streaming against a queue-based sum model.
import dadda_cpa_pipe_pkg::*;

module tb_dadda_cpa_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  row_t        row_a = '0, row_b = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, ovf;
  row_t        prod;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] q[$];
  logic       have_hold = 1'b0;
  logic [W:0] held;

  typedef struct {
    row_t       a;
    row_t       b;
    row_t       exp_prod;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[9];

  dadda_cpa_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_a     (row_a),
    .row_b     (row_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model each accepted pair as a plain W+1-bit sum, check
  // outputs in order and hold-stability during stalls.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold && out_valid) chk("stall_stable", {15'd0, ovf, prod}, {15'd0, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h, expected no output", prod);
        end else begin
          chk("stream", {15'd0, ovf, prod}, {15'd0, q.pop_front()});
        end
      end
      if (in_valid && in_ready) q.push_back({1'b0, row_a} + {1'b0, row_b});
      have_hold = out_valid && !out_ready;
      held      = {ovf, prod};
    end
  end

  initial begin
    int sent, cyc;
    logic acc;

    tbl[0] = '{16'hFE00, 16'h0001, 16'hFE01, 1'b0};
    tbl[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[4] = '{16'h0001, 16'h0001, 16'h0002, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[8] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};

    // Reset and idle.
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    chk("idle_out_valid", out_valid, 0);

    // Directed table: single items, no backpressure, check latency too.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      row_a = tbl[i].a; row_b = tbl[i].b; in_valid = 1'b1;
      #1 chk("tbl_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("tbl_lat1_valid", out_valid, 0);
      step();
      chk("tbl_lat2_valid", out_valid, 1);
      chk("tbl_prod", prod, tbl[i].exp_prod);
      chk("tbl_ovf", ovf, tbl[i].exp_ovf);
      step();
    end

    // Backpressure: two accepts fill the pipe, third offer stalls.
    out_ready = 1'b0;
    row_b = '0;
    row_a = 16'h0001; in_valid = 1'b1;
    #1 chk("bp_rdy1", in_ready, 1);
    step();
    row_a = 16'h0002;
    #1 chk("bp_rdy2", in_ready, 1);
    step();
    row_a = 16'h0003;
    #1 chk("bp_rdy3", in_ready, 0);
    chk("bp_prod_hold", prod, 16'h0001);
    step(); step();
    chk("bp_rdy_still", in_ready, 0);
    chk("bp_prod_still", prod, 16'h0001);
    chk("bp_valid_still", out_valid, 1);
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out2", prod, 16'h0002);
    step();
    chk("bp_out3", prod, 16'h0003);
    chk("bp_out3_valid", out_valid, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Reset with two items in flight: neither may ever emerge.
    out_ready = 1'b0;
    row_a = 16'h0A0A; row_b = 16'h0101; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_prod", prod, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_out", out_valid, 0);
    end

    // Random streaming with random valid/ready.
    sent = 0; cyc = 0;
    row_a = row_t'($urandom); row_b = row_t'($urandom);
    while (sent < 256 && cyc < 5000) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      #1;
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        row_a = row_t'($urandom); row_b = row_t'($urandom);
      end
    end
    chk("rand_all_sent", sent, 256);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    step();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
